exe_mem_pipe_buf: RTL and testbench

//  Parametrised EXE->MEM pipeline boundary. Successor to the plain EXE stage register.

---
 rtl/exe_mem_pipe_buf_pkg.sv | 19 +
 rtl/exe_mem_pipe_buf_skid.sv | 81 ++++++++
 rtl/exe_mem_pipe_buf.sv | 83 ++++++++
 tb/tb_exe_mem_pipe_buf.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pipe_buf_pkg.sv
// rtl/exe_mem_pipe_buf_pkg.sv - shared widths and buffer state encoding for the EXE->MEM boundary
package exe_mem_pipe_buf_pkg;

    // Default field widths of the core datapath
    localparam int ADDRESS_LEN         = 32;
    localparam int REGISTER_LEN        = 32;
    localparam int REGFILE_ADDRESS_LEN = 4;

    // Number of side-effecting control bits carried per instruction (wb, mr, mw)
    localparam int CTRL_BITS = 3;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/exe_mem_pipe_buf_skid.sv
// rtl/exe_mem_pipe_buf_skid.sv - generic two-entry skid buffer with flush
module pipe_skid_buf
    import exe_mem_pipe_buf_pkg::*;
#(
    parameter int                   PAYLOAD_W = 8,
    parameter logic [PAYLOAD_W-1:0] CTRL_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    buf_state_t           state;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;

    // The main entry is always the head of the queue
    assign out_data = main_q;

    // Occupancy FSM; handshake outputs are registered alongside the state so
    // in_ready never depends combinationally on out_ready. Flush wins over
    // every transfer and strips the control bits so a stale entry can never
    // cause a write even if its data is later observed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= main_q & ~CTRL_MASK;
            skid_q    <= skid_q & ~CTRL_MASK;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_q    <= in_data;
                        state     <= ST_BUSY;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        skid_q   <= in_data;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_q   <= skid_q;
                        state    <= ST_BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_pipe_buf.sv
// rtl/exe_mem_pipe_buf.sv - EXE->MEM pipeline boundary with handshake, flush and stall counter
module exe_mem_pipe_buf
    import exe_mem_pipe_buf_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int DATA_W = REGISTER_LEN,
    parameter int DEST_W = REGFILE_ADDRESS_LEN,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              wb_enable_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              wb_enable_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int LOW_W     = 2 * DATA_W + DEST_W;
    localparam int PAYLOAD_W = ADDR_W + CTRL_BITS + LOW_W;

    // Control bits sit directly below pc in the packed payload
    localparam logic [PAYLOAD_W-1:0] CTRL_MASK =
        {{ADDR_W{1'b0}}, {CTRL_BITS{1'b1}}, {LOW_W{1'b0}}};

    logic [PAYLOAD_W-1:0] in_data;
    logic [PAYLOAD_W-1:0] out_data;
    logic                 wb_head;
    logic                 mr_head;
    logic                 mw_head;

    // Pack MSB-first: pc, wb, mr, mw, alu, rm, dest
    assign in_data = {pc_in, wb_enable_in, mem_read_in, mem_write_in,
                      alu_res_in, val_rm_in, dest_in};

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W),
        .CTRL_MASK (CTRL_MASK)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign {pc_out, wb_head, mr_head, mw_head,
            alu_res_out, val_rm_out, dest_out} = out_data;

    // A bubble must never write the register file or touch memory
    assign wb_enable_out = wb_head & out_valid;
    assign mem_read_out  = mr_head & out_valid;
    assign mem_write_out = mw_head & out_valid;

    // Saturating count of cycles where MEM holds back a valid instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exe_mem_pipe_buf.sv
// tb/tb_exe_mem_pipe_buf.sv - self-checking bench for exe_mem_pipe_buf
module tb_exe_mem_pipe_buf;

    typedef struct packed {
        logic [31:0] pc;
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dest;
    } pl_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    pl_t         drv;

    logic        in_ready, out_valid, wb_enable_out, mem_read_out, mem_write_out;
    logic [31:0] pc_out, alu_res_out, val_rm_out;
    logic [3:0]  dest_out;
    logic [15:0] stall_cnt;

    logic        in_ready_2, out_valid_2, wb_2, mr_2, mw_2;
    logic [31:0] pc_2, alu_2, rm_2;
    logic [3:0]  dest_2;
    logic [1:0]  stall_cnt_2;

    int errors = 0;
    int checks = 0;
    pl_t q[$];
    int unsigned stall_m = 0;

    exe_mem_pipe_buf u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(drv.pc), .wb_enable_in(drv.wb), .mem_read_in(drv.mr), .mem_write_in(drv.mw),
        .alu_res_in(drv.alu), .val_rm_in(drv.rm), .dest_in(drv.dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .dest_out(dest_out), .stall_cnt(stall_cnt)
    );

    exe_mem_pipe_buf #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_2),
        .pc_in(drv.pc), .wb_enable_in(drv.wb), .mem_read_in(drv.mr), .mem_write_in(drv.mw),
        .alu_res_in(drv.alu), .val_rm_in(drv.rm), .dest_in(drv.dest),
        .out_valid(out_valid_2), .out_ready(out_ready),
        .pc_out(pc_2), .wb_enable_out(wb_2), .mem_read_out(mr_2),
        .mem_write_out(mw_2), .alu_res_out(alu_2), .val_rm_out(rm_2),
        .dest_out(dest_2), .stall_cnt(stall_cnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pl_t mk(input logic [31:0] pc, input logic [2:0] ctl);
        pl_t p;
        p.pc   = pc;
        p.wb   = ctl[2];
        p.mr   = ctl[1];
        p.mw   = ctl[0];
        p.alu  = $urandom;
        p.rm   = $urandom;
        p.dest = 4'($urandom);
        return p;
    endfunction

    // Compare every observable output against the queue model
    task automatic check_all(input string tag);
        int unsigned sat2;
        sat2 = (stall_m > 3) ? 3 : stall_m;
        chk({tag, " out_valid"}, out_valid, q.size() > 0);
        chk({tag, " in_ready"}, in_ready, q.size() < 2);
        chk({tag, " stall_cnt"}, stall_cnt, stall_m);
        chk({tag, " stall_cnt_w2"}, stall_cnt_2, sat2);
        if (q.size() > 0) begin
            chk({tag, " pc"}, pc_out, q[0].pc);
            chk({tag, " wb"}, wb_enable_out, q[0].wb);
            chk({tag, " mr"}, mem_read_out, q[0].mr);
            chk({tag, " mw"}, mem_write_out, q[0].mw);
            chk({tag, " alu"}, alu_res_out, q[0].alu);
            chk({tag, " rm"}, val_rm_out, q[0].rm);
            chk({tag, " dest"}, dest_out, q[0].dest);
        end else begin
            chk({tag, " bubble ctl"}, {wb_enable_out, mem_read_out, mem_write_out}, 3'b000);
        end
    endtask

    // Apply one cycle of stimulus, advance the queue model, then check
    task automatic step(input string tag, input logic iv, input logic ordy,
                        input logic fl, input pl_t p);
        int sz;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        drv       = p;
        @(posedge clk);
        sz = q.size();
        if (sz > 0 && !ordy && stall_m < 65535) stall_m++;
        if (fl) begin
            q.delete();
        end else begin
            if (sz > 0 && ordy) void'(q.pop_front());
            if (iv && sz < 2) q.push_back(p);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        pl_t c;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset pc", pc_out, 32'h0);
        chk("reset alu", alu_res_out, 32'h0);
        chk("reset stall", stall_cnt, 16'h0);
        rst = 1'b1;

        // 1: streaming, one-cycle latency
        step("t1 s0", 1, 1, 0, mk(32'h0, 3'b100));
        chk("t1 pc0", pc_out, 32'h0);
        step("t1 s1", 1, 1, 0, mk(32'h4, 3'b010));
        chk("t1 pc4", pc_out, 32'h4);
        step("t1 s2", 1, 1, 0, mk(32'h8, 3'b001));
        chk("t1 pc8", pc_out, 32'h8);
        step("t1 s3", 0, 1, 0, mk(32'hc, 3'b111));

        // 2: back-pressure to FULL, C offered while FULL
        step("t2 a", 1, 0, 0, mk(32'h10, 3'b100));
        step("t2 b", 1, 0, 0, mk(32'h14, 3'b010));
        c = mk(32'h18, 3'b001);
        step("t2 c0", 1, 0, 0, c);
        step("t2 c1", 1, 0, 0, c);
        chk("t2 stall3", stall_cnt, 16'd3);
        chk("t2 full in_ready", in_ready, 1'b0);
        chk("t2 head A", pc_out, 32'h10);
        step("t2 drainA", 1, 1, 0, c);
        chk("t2 head B", pc_out, 32'h14);
        step("t2 drainB", 1, 1, 0, c);
        chk("t2 head C", pc_out, 32'h18);
        step("t2 drainC", 0, 1, 0, c);

        // 3: flush while FULL with a new offer in the same cycle
        step("t3 d", 1, 0, 0, mk(32'h20, 3'b111));
        step("t3 e", 1, 0, 0, mk(32'h24, 3'b111));
        step("t3 flush", 1, 0, 1, mk(32'h28, 3'b111));
        chk("t3 flush out_valid", out_valid, 1'b0);
        chk("t3 flush in_ready", in_ready, 1'b1);
        step("t3 after0", 0, 1, 0, mk(32'h2c, 3'b111));
        step("t3 after1", 0, 1, 0, mk(32'h2c, 3'b111));

        // 4: bubbles never carry control bits
        for (int i = 0; i < 3; i++) begin
            step("t4 bubble", 0, i[0], 0, mk(32'h30, 3'b111));
            chk("t4 wb gated", wb_enable_out, 1'b0);
        end

        // 5: async reset mid-FULL between edges
        step("t5 g", 1, 0, 0, mk(32'h40, 3'b111));
        step("t5 h", 1, 0, 0, mk(32'h44, 3'b111));
        #2;
        rst = 1'b0;
        #1;
        chk("t5 out_valid", out_valid, 1'b0);
        chk("t5 in_ready", in_ready, 1'b1);
        chk("t5 pc", pc_out, 32'h0);
        chk("t5 alu", alu_res_out, 32'h0);
        chk("t5 wb", wb_enable_out, 1'b0);
        chk("t5 stall", stall_cnt, 16'h0);
        chk("t5 stall w2", stall_cnt_2, 2'h0);
        q.delete();
        stall_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 6: narrow counter saturates
        step("t6 load", 1, 0, 0, mk(32'h50, 3'b100));
        for (int i = 0; i < 6; i++) step("t6 hold", 0, 0, 0, mk(32'h54, 3'b000));
        chk("t6 stall w2 sat", stall_cnt_2, 2'd3);
        chk("t6 stall w16", stall_cnt, 16'd6);
        step("t6 drain", 0, 1, 0, mk(32'h58, 3'b000));

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), mk($urandom & 32'hffff_fffc, 3'($urandom)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
